// File: rtl/sprite_layer_pkg.sv
// Shared widths and the timing bundle carried through the sprite layer delay pipe.
package sprite_layer_pkg;

  localparam int HCNT_W          = 11;
  localparam int RGB_W           = 12;
  localparam int DEFAULT_COORD_W = 12;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [HCNT_W-1:0] vcount;
    logic              hsync;
    logic              hblnk;
    logic              vsync;
    logic              vblnk;
  } pixel_timing_t;

endpackage

// File: rtl/sprite_layer_mux_hit_cmp.sv
// Rectangle hit test for one sprite channel; sums carry an extra bit so sprites clip at the edge.
module sprite_hit_cmp
  import sprite_layer_pkg::*;
#(
  parameter int COORD_W = DEFAULT_COORD_W,
  parameter int OBJ_W   = 32,
  parameter int OBJ_H   = 32
) (
  input  logic [HCNT_W-1:0]  hcount_i,
  input  logic [HCNT_W-1:0]  vcount_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic               en_i,
  output logic               hit_o
);

  localparam int SUM_W = COORD_W + 1;

  logic [SUM_W-1:0] hExt;
  logic [SUM_W-1:0] vExt;
  logic [SUM_W-1:0] xLo;
  logic [SUM_W-1:0] yLo;
  logic [SUM_W-1:0] xHi;
  logic [SUM_W-1:0] yHi;

  assign hExt = SUM_W'(hcount_i);
  assign vExt = SUM_W'(vcount_i);
  assign xLo  = {1'b0, x_i};
  assign yLo  = {1'b0, y_i};
  assign xHi  = xLo + SUM_W'(OBJ_W);
  assign yHi  = yLo + SUM_W'(OBJ_H);

  assign hit_o = en_i & (hExt >= xLo) & (hExt < xHi) & (vExt >= yLo) & (vExt < yHi);

endmodule

// File: rtl/sprite_layer_mux.sv
// N-channel fixed-priority sprite overlay with vblank-latched shadow positions, 2-cycle latency.
// Optional per-frame channel-0 collision flags are built when SPRITE_LAYER_COLLISION_EN is defined.
module sprite_layer_mux
  import sprite_layer_pkg::*;
#(
  parameter int N_OBJ   = 4,
  parameter int OBJ_W   = 32,
  parameter int OBJ_H   = 32,
  parameter int COORD_W = DEFAULT_COORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [HCNT_W-1:0]        hcount_in,
  input  logic [HCNT_W-1:0]        vcount_in,
  input  logic                     hsync_in,
  input  logic                     hblnk_in,
  input  logic                     vsync_in,
  input  logic                     vblnk_in,
  input  logic [RGB_W-1:0]         rgb_in,
  input  logic [N_OBJ*COORD_W-1:0] x_pos,
  input  logic [N_OBJ*COORD_W-1:0] y_pos,
  input  logic [N_OBJ-1:0]         obj_en,
  input  logic [N_OBJ*RGB_W-1:0]   obj_color,
  output logic [HCNT_W-1:0]        hcount_out,
  output logic [HCNT_W-1:0]        vcount_out,
  output logic                     hsync_out,
  output logic                     hblnk_out,
  output logic                     vsync_out,
  output logic                     vblnk_out,
  output logic [RGB_W-1:0]         rgb_out,
  output logic                     frame_latch,
  output logic [N_OBJ-1:0]         overlap
);

  logic                     vblnkPrev_q;
  logic                     latchPulse;
  logic [N_OBJ*COORD_W-1:0] xShadow_q;
  logic [N_OBJ*COORD_W-1:0] yShadow_q;
  logic [N_OBJ-1:0]         enShadow_q;
  logic [N_OBJ*RGB_W-1:0]   colorShadow_q;
  logic                     frameLatch_q;

  pixel_timing_t            timingIn;
  pixel_timing_t            timing1_q;
  pixel_timing_t            timing2_q;
  logic [RGB_W-1:0]         rgb1_q;
  logic [RGB_W-1:0]         rgb2_q;
  logic [N_OBJ-1:0]         hitRaw;
  logic [N_OBJ-1:0]         hit1_q;
  logic [RGB_W-1:0]         rgbMux_d;

  assign timingIn   = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};
  assign latchPulse = vblnk_in & ~vblnkPrev_q;

  // Sprite parameters only change on the rising edge of vblank so a frame is drawn from one consistent set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnkPrev_q   <= 1'b0;
      xShadow_q     <= '0;
      yShadow_q     <= '0;
      enShadow_q    <= '0;
      colorShadow_q <= '0;
      frameLatch_q  <= 1'b0;
    end else begin
      vblnkPrev_q  <= vblnk_in;
      frameLatch_q <= latchPulse;
      if (latchPulse) begin
        xShadow_q     <= x_pos;
        yShadow_q     <= y_pos;
        enShadow_q    <= obj_en;
        colorShadow_q <= obj_color;
      end
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : gen_hit
    sprite_hit_cmp #(
      .COORD_W (COORD_W),
      .OBJ_W   (OBJ_W),
      .OBJ_H   (OBJ_H)
    ) u_hit (
      .hcount_i (hcount_in),
      .vcount_i (vcount_in),
      .x_i      (xShadow_q[g*COORD_W +: COORD_W]),
      .y_i      (yShadow_q[g*COORD_W +: COORD_W]),
      .en_i     (enShadow_q[g]),
      .hit_o    (hitRaw[g])
    );
  end

  // Walk from the lowest priority upward so channel 0 wins; blanking overrides everything.
  always_comb begin
    rgbMux_d = rgb1_q;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit1_q[i]) rgbMux_d = colorShadow_q[i*RGB_W +: RGB_W];
    end
    if (timing1_q.hblnk | timing1_q.vblnk) rgbMux_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timing1_q <= '0;
      timing2_q <= '0;
      rgb1_q    <= '0;
      rgb2_q    <= '0;
      hit1_q    <= '0;
    end else begin
      timing1_q <= timingIn;
      rgb1_q    <= rgb_in;
      hit1_q    <= hitRaw;
      timing2_q <= timing1_q;
      rgb2_q    <= rgbMux_d;
    end
  end

  assign hcount_out  = timing2_q.hcount;
  assign vcount_out  = timing2_q.vcount;
  assign hsync_out   = timing2_q.hsync;
  assign hblnk_out   = timing2_q.hblnk;
  assign vsync_out   = timing2_q.vsync;
  assign vblnk_out   = timing2_q.vblnk;
  assign rgb_out     = rgb2_q;
  assign frame_latch = frameLatch_q;

`ifdef SPRITE_LAYER_COLLISION_EN
  logic [N_OBJ-1:0] acc_q;
  logic [N_OBJ-1:0] overlap_q;
  logic [N_OBJ-1:0] accNew;

  always_comb begin
    accNew = '0;
    if (!(timing1_q.hblnk | timing1_q.vblnk)) begin
      for (int i = 1; i < N_OBJ; i++) accNew[i] = hit1_q[0] & hit1_q[i];
    end
  end

  // The pixel still in stage 1 at the latch edge belongs to the finishing frame, so it is folded into the report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      overlap_q <= '0;
    end else if (latchPulse) begin
      overlap_q <= acc_q | accNew;
      acc_q     <= '0;
    end else begin
      acc_q <= acc_q | accNew;
    end
  end

  assign overlap = overlap_q;
`else
  assign overlap = '0;
`endif

endmodule

// File: tb/tb_sprite_layer_mux.sv
// Self-checking bench for sprite_layer_mux: vector table plus model-fed scoreboard on the 2-cycle output.
module tb_sprite_layer_mux;
  import sprite_layer_pkg::*;

  localparam int N  = 4;
  localparam int CW = 12;
  localparam int OW = 32;
  localparam int OH = 32;
`ifdef SPRITE_LAYER_COLLISION_EN
  localparam bit COLL_ON = 1'b1;
`else
  localparam bit COLL_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [10:0]     hcountIn, vcountIn;
  logic            hsyncIn, hblnkIn, vsyncIn, vblnkIn;
  logic [11:0]     rgbIn;
  logic [N*CW-1:0] xPos, yPos;
  logic [N-1:0]    objEn;
  logic [N*12-1:0] objColor;
  logic [10:0]     hcountOut, vcountOut;
  logic            hsyncOut, hblnkOut, vsyncOut, vblnkOut;
  logic [11:0]     rgbOut;
  logic            frameLatch;
  logic [N-1:0]    overlapOut;

  always #5 clk = ~clk;

  sprite_layer_mux #(.N_OBJ(N), .OBJ_W(OW), .OBJ_H(OH), .COORD_W(CW)) dut (
    .clk (clk), .rst (rst),
    .hcount_in (hcountIn), .vcount_in (vcountIn),
    .hsync_in (hsyncIn), .hblnk_in (hblnkIn), .vsync_in (vsyncIn), .vblnk_in (vblnkIn),
    .rgb_in (rgbIn), .x_pos (xPos), .y_pos (yPos), .obj_en (objEn), .obj_color (objColor),
    .hcount_out (hcountOut), .vcount_out (vcountOut),
    .hsync_out (hsyncOut), .hblnk_out (hblnkOut), .vsync_out (vsyncOut), .vblnk_out (vblnkOut),
    .rgb_out (rgbOut), .frame_latch (frameLatch), .overlap (overlapOut)
  );

  typedef struct {
    logic [11:0] rgb;
    logic [25:0] timing;
    string       tag;
  } exp_t;

  typedef struct {
    int          h;
    int          v;
    bit          hb;
    bit          vb;
    logic [11:0] rgb;
    logic [11:0] expRgb;
    string       tag;
  } vec_t;

  exp_t        sbQueue[$];
  vec_t        vecs[14];
  int          checks = 0;
  int          passes = 0;
  int          mX[N], mY[N];
  bit          mEn[N];
  logic [11:0] mColor[N];
  bit          prevVb;
  logic [N-1:0] mAcc, mOvl;
  int          latchExpected = 0;
  int          latchSeen = 0;

  always @(posedge clk) if (frameLatch === 1'b1) latchSeen++;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, actual running, required finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: actual %h, required %h", tag, act, req);
  endtask

  function automatic bit modelHit(int i, int h, int v);
    return mEn[i] && h >= mX[i] && h < mX[i] + OW && v >= mY[i] && v < mY[i] + OH;
  endfunction

  function automatic logic [11:0] modelRgb(int h, int v, bit hb, bit vb, logic [11:0] rgbv);
    if (hb || vb) return 12'h000;
    for (int i = 0; i < N; i++) if (modelHit(i, h, v)) return mColor[i];
    return rgbv;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < N; i++) begin
      mX[i] = 0; mY[i] = 0; mEn[i] = 1'b0; mColor[i] = 12'h000;
    end
    prevVb = 1'b0;
    mAcc   = '0;
    mOvl   = '0;
    sbQueue.delete();
  endtask

  task automatic setChannel(input int i, input int x, input int y, input logic [11:0] c, input bit en);
    xPos[i*CW +: CW]  = CW'(x);
    yPos[i*CW +: CW]  = CW'(y);
    objColor[i*12 +: 12] = c;
    objEn[i] = en;
  endtask

  // One pixel per call: compare the pixel driven two cycles earlier, drive this one, update the model.
  task automatic applyStimulus(input int h, input int v, input bit hs, input bit hb, input bit vs,
                               input bit vb, input logic [11:0] rgbv, input logic [11:0] expRgb,
                               input string tag);
    exp_t e;
    @(negedge clk);
    if (sbQueue.size() == 2) begin
      e = sbQueue.pop_front();
      check({e.tag, " rgb"}, 32'(rgbOut), 32'(e.rgb));
      check({e.tag, " timing"},
            32'({hcountOut, vcountOut, hsyncOut, hblnkOut, vsyncOut, vblnkOut}), 32'(e.timing));
    end
    hcountIn = 11'(h); vcountIn = 11'(v);
    hsyncIn = hs; hblnkIn = hb; vsyncIn = vs; vblnkIn = vb; rgbIn = rgbv;
    e.rgb    = expRgb;
    e.timing = {11'(h), 11'(v), hs, hb, vs, vb};
    e.tag    = tag;
    sbQueue.push_back(e);
    if (COLL_ON && !hb && !vb) begin
      for (int i = 1; i < N; i++) if (modelHit(0, h, v) && modelHit(i, h, v)) mAcc[i] = 1'b1;
    end
    if (vb && !prevVb) begin
      mOvl = mAcc;
      mAcc = '0;
      latchExpected++;
      for (int i = 0; i < N; i++) begin
        mX[i]     = int'(xPos[i*CW +: CW]);
        mY[i]     = int'(yPos[i*CW +: CW]);
        mEn[i]    = objEn[i];
        mColor[i] = objColor[i*12 +: 12];
      end
    end
    prevVb = vb;
  endtask

  task automatic drivePixel(input int h, input int v, input string tag);
    applyStimulus(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AB, modelRgb(h, v, 1'b0, 1'b0, 12'h0AB), tag);
  endtask

  task automatic vblankEdge();
    applyStimulus(0, 768, 1'b1, 1'b1, 1'b1, 1'b1, 12'h123, 12'h000, "vblank rise");
    @(posedge clk); #1;
    check("frame_latch pulse", 32'(frameLatch), 32'd1);
    check("overlap publish", 32'(overlapOut), 32'(mOvl));
    repeat (3) applyStimulus(0, 769, 1'b1, 1'b1, 1'b0, 1'b1, 12'h123, 12'h000, "vblank");
    check("frame_latch idle", 32'(frameLatch), 32'd0);
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h123, 12'h000, "hblank");
    check("latch count", 32'(latchSeen), 32'(latchExpected));
  endtask

  task automatic checkOutputsZero(input string tag);
    check({tag, " rgb_out"}, 32'(rgbOut), 32'd0);
    check({tag, " hcount_out"}, 32'(hcountOut), 32'd0);
    check({tag, " vsync_out"}, 32'(vsyncOut), 32'd0);
    check({tag, " frame_latch"}, 32'(frameLatch), 32'd0);
    check({tag, " overlap"}, 32'(overlapOut), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{10,   10,  1'b0, 1'b0, 12'h0AB, 12'h0AB, "pass active a"};
    vecs[1]  = '{500,  300, 1'b0, 1'b0, 12'h0AB, 12'h0AB, "pass active b"};
    vecs[2]  = '{1023, 767, 1'b0, 1'b0, 12'h0AB, 12'h0AB, "pass last pixel"};
    vecs[3]  = '{1030, 10,  1'b1, 1'b0, 12'h0AB, 12'h000, "pass hblank"};
    vecs[4]  = '{10,   770, 1'b0, 1'b1, 12'h0AB, 12'h000, "pass vblank"};
    vecs[5]  = '{115,  115, 1'b0, 1'b0, 12'h0AB, 12'hF00, "prio ch0 over ch1"};
    vecs[6]  = '{140,  140, 1'b0, 1'b0, 12'h0AB, 12'h0F0, "ch1 only"};
    vecs[7]  = '{100,  100, 1'b0, 1'b0, 12'h0AB, 12'hF00, "ch0 corner"};
    vecs[8]  = '{131,  131, 1'b0, 1'b0, 12'h0AB, 12'hF00, "ch0 last pixel"};
    vecs[9]  = '{132,  132, 1'b0, 1'b0, 12'h0AB, 12'h0F0, "ch1 past ch0"};
    vecs[10] = '{141,  141, 1'b0, 1'b0, 12'h0AB, 12'h0F0, "ch1 last pixel"};
    vecs[11] = '{142,  141, 1'b0, 1'b0, 12'h0AB, 12'h0AB, "right of ch1"};
    vecs[12] = '{99,   100, 1'b0, 1'b0, 12'h0AB, 12'h0AB, "left of ch0"};
    vecs[13] = '{120,  120, 1'b1, 1'b0, 12'h0AB, 12'h000, "hblank over sprites"};

    resetModel();
    rst = 1'b1;
    hcountIn = 11'd5; vcountIn = 11'd7; hsyncIn = 1'b1; hblnkIn = 1'b0;
    vsyncIn = 1'b1; vblnkIn = 1'b0; rgbIn = 12'hFFF;
    xPos = '0; yPos = '0; objEn = '0; objColor = '0;
    repeat (3) @(negedge clk);
    checkOutputsZero("reset");
    hblnkIn = 1'b1; vsyncIn = 1'b0;
    rst = 1'b0;
    $display("[TB] reset released, pass-through vectors");

    for (int i = 0; i < 5; i++)
      applyStimulus(vecs[i].h, vecs[i].v, 1'b0, vecs[i].hb, 1'b0, vecs[i].vb,
                    vecs[i].rgb, vecs[i].expRgb, vecs[i].tag);
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h123, 12'h000, "hblank");

    $display("[TB] single sprite at (100,200)");
    setChannel(0, 100, 200, 12'hF00, 1'b1);
    drivePixel(105, 205, "before latch");
    vblankEdge();
    foreach (vecs[k]) if (k < 1) drivePixel(100, 200, "ch0 first pixel");
    for (int v = 199; v <= 232; v += 11)
      for (int h = 98; h <= 133; h++) drivePixel(h, v, "ch0 row sweep");
    drivePixel(133, 232, "ch0 row sweep");
    for (int h = 99; h <= 132; h += 11)
      for (int v = 198; v <= 233; v++) drivePixel(h, v, "ch0 column sweep");
    for (int v = 198; v <= 233; v++) drivePixel(131, v, "ch0 right edge");

    $display("[TB] two sprites, priority and mid-frame move");
    setChannel(0, 100, 100, 12'hF00, 1'b1);
    setChannel(1, 110, 110, 12'h0F0, 1'b1);
    vblankEdge();
    for (int i = 5; i < 14; i++)
      applyStimulus(vecs[i].h, vecs[i].v, 1'b0, vecs[i].hb, 1'b0, vecs[i].vb,
                    vecs[i].rgb, vecs[i].expRgb, vecs[i].tag);
    setChannel(0, 300, 100, 12'hF00, 1'b1);
    drivePixel(115, 115, "moved ch0 not yet latched");
    applyStimulus(115, 115, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AB, 12'hF00, "old position held");
    vblankEdge();
    applyStimulus(115, 115, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AB, 12'h0F0, "ch0 moved away");
    applyStimulus(305, 105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AB, 12'hF00, "ch0 new position");

    $display("[TB] sprites near coordinate maximum");
    setChannel(0, 0, 0, 12'h000, 1'b0);
    setChannel(1, 0, 0, 12'h000, 1'b0);
    setChannel(2, 4090, 0, 12'h00F, 1'b1);
    setChannel(3, 0, 4090, 12'h0F0, 1'b1);
    vblankEdge();
    for (int h = 0; h <= 25; h++) drivePixel(h, 5, "no column wrap");
    for (int v = 0; v <= 25; v++) drivePixel(10, v, "no row wrap");
    for (int h = 2040; h <= 2047; h++) drivePixel(h, 5, "far right column");

    $display("[TB] collision reporting");
    setChannel(0, 100, 100, 12'hF00, 1'b1);
    setChannel(2, 0, 0, 12'h000, 1'b0);
    setChannel(3, 120, 120, 12'h00F, 1'b1);
    vblankEdge();
    drivePixel(125, 125, "ch0 over ch3");
    drivePixel(90, 90, "outside both");
    setChannel(3, 500, 500, 12'h00F, 1'b1);
    vblankEdge();
    check("overlap ch3 flagged", 32'(overlapOut), COLL_ON ? 32'h8 : 32'h0);
    drivePixel(125, 125, "ch0 alone");
    drivePixel(505, 505, "ch3 alone");
    vblankEdge();
    check("overlap cleared", 32'(overlapOut), 32'h0);
    setChannel(3, 120, 120, 12'h00F, 1'b1);
    vblankEdge();
    drivePixel(125, 125, "ch0 over ch3 again");
    vblankEdge();
    drivePixel(125, 125, "before mid-frame reset");
    drivePixel(126, 125, "before mid-frame reset");

    #2 rst = 1'b1;
    #1 checkOutputsZero("mid-frame reset");
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    drivePixel(125, 125, "pass after reset");
    drivePixel(140, 140, "pass after reset");
    repeat (2) applyStimulus(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h123, 12'h000, "flush");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
